lif_neuron_scheduler: RTL and testbench
=======================================

Name: lif_neuron_scheduler

Overview:
- Time-multiplexes one combinational LIF neuron datapath (w, x, shift, previus_u, minus_teta, was_spike in; u_out, is_spike out) across N_NEURONS virtual neurons.
- Holds per-neuron weights, membrane potential and last-spike bit, plus the global threshold and leak shift.
- Accepts one input vector per timestep through a valid/ready handshake. Evaluates the neurons one per cycle and returns a spike vector through a second valid/ready handshake.
- Configuration writes are accepted only while the block is idle.

Parameters:
- N_NEURONS, 4, number of virtual neurons; must be ≥1.
- INPUTS, 8, synapses per neuron; this is the width of x and of each weight word.
- U_WIDTH, 5, membrane potential width; equals the datapath output precision.
- IDX_W, $clog2(N_NEURONS) with a minimum of 1, neuron index width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  an input vector is offered
- in_ready  out  1  scheduler can accept an input vector
- in_x  in  INPUTS  input spike vector for this timestep
- out_valid  out  1  spike vector is available
- out_ready  in  1  consumer accepts the spike vector
- out_spikes  out  N_NEURONS  bit i is the spike of neuron i
- step_count  out  16  number of completed timesteps, wraps modulo 2^16
- cfg_we  in  1  configuration write strobe
- cfg_sel  in  2  0 = weight, 1 = threshold, 2 = shift, 3 = clear neuron state
- cfg_addr  in  IDX_W  target neuron for sel 0 and sel 3
- cfg_data  in  INPUTS  write data
- cfg_ready  out  1  high in IDLE; writes are committed only when this is high
- dp_w  out  INPUTS  weights of the current neuron
- dp_x  out  INPUTS  latched input vector
- dp_shift  out  3  leak shift
- dp_previus_u  out  U_WIDTH  stored potential of the current neuron
- dp_minus_teta  out  U_WIDTH  negated threshold
- dp_was_spike  out  1  stored spike bit of the current neuron
- dp_u_out  in  U_WIDTH  new potential from the datapath (same cycle)
- dp_is_spike  in  1  spike from the datapath (same cycle)

Behaviour:
- Reset values (asynchronous, all registers):
  - state = IDLE, idx = 0, x_reg = 0.
  - All weights = all ones. All u_mem = 0. All spk_mem = 0.
  - thr = 5, shift = 0.
  - out_spikes = 0, out_valid = 0, step_count = 0.
- Outputs derived from state: in_ready = cfg_ready = (state==IDLE).
- Datapath drive:
  - dp_w = wmem[idx], dp_previus_u = u_mem[idx], dp_was_spike = spk_mem[idx].
  - dp_x = x_reg, dp_shift = shift.
  - dp_minus_teta = (−thr) mod 2^U_WIDTH; at reset this is 5'b11011.
- IDLE:
  - in_valid at a rising edge: x_reg <= in_x, idx <= 0, state <= RUN.
  - Config write at a rising edge (cfg_we=1):
    - sel0: wmem[cfg_addr] <= cfg_data.
    - sel1: thr <= cfg_data[U_WIDTH-1:0].
    - sel2: shift <= cfg_data[2:0].
    - sel3: u_mem[cfg_addr] <= 0 and spk_mem[cfg_addr] <= 0.
  - A config write and an in_valid in the same cycle both commit. The RUN phase then uses the new configuration.
  - A write with cfg_addr ≥ N_NEURONS for sel0 or sel3 is dropped; sel1 and sel2 ignore cfg_addr.
- RUN, one neuron per cycle:
  - Each edge: u_mem[idx] <= dp_u_out, spk_mem[idx] <= dp_is_spike, out_spikes[idx] <= dp_is_spike.
  - If idx == N_NEURONS−1: state <= DONE, out_valid <= 1, step_count <= step_count+1, idx <= 0. Otherwise idx <= idx+1.
  - cfg_we and in_valid are ignored; no state changes from them.
- DONE:
  - out_valid = 1 and out_spikes are held stable until out_ready is high at an edge.
  - At that edge: out_valid <= 0, state <= IDLE. out_spikes keeps its value.
- Latency: if in_valid is accepted at edge E0, out_valid is high after edge E0+N_NEURONS. The earliest next acceptance is the edge after out_ready is seen.
- Throughput: one timestep per N_NEURONS+2 cycles when out_ready is held high.
- out_ready outside DONE has no effect.
- The scheduler does no arithmetic on the potential; it stores dp_u_out exactly as returned.
- A reset assertion in any state, including mid-RUN, returns all registers to their reset values immediately. A partially updated timestep is discarded.

Test Plan:
- Reset defaults: assert reset, then release. Check in_ready=1, out_valid=0, step_count=0, dp_w=8'hFF, dp_minus_teta=5'b11011, dp_shift=0.
- Sequencing with a stub datapath (u_out = previus_u+1, is_spike = previus_u[0]): apply in_x=8'hA5 with in_valid and out_ready=1.
  - dp_x=8'hA5 for 4 cycles.
  - out_valid rises 4 edges after acceptance with out_spikes=4'b0000.
  - A second step gives out_spikes=4'b1111, u_mem all 2, step_count=2.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. out_spikes and out_valid stay stable, in_ready=0 and in_valid is ignored. Raising out_ready returns the block to IDLE one edge later.
- Config:
  - Write weight 8'h3C to neuron 2, thr=7, shift=3; dp_w=8'h3C only while idx=2, dp_minus_teta=5'b11001, dp_shift=3.
  - A cfg_we during RUN leaves all of these unchanged.
  - A sel3 clear of neuron 1 zeroes its u_mem and spk_mem.
- Simultaneous events and reset:
  - cfg_we (thr=3) with in_valid in the same IDLE cycle: dp_minus_teta=5'b11101 throughout that RUN.
  - Assert reset at idx=2: state returns to IDLE, u_mem=0, weights=8'hFF, step_count unchanged at 0.

Source files
------------

// File: rtl/lif_neuron_scheduler.sv
// Time-multiplexes one external combinational LIF datapath over N_NEURONS virtual
// neurons: accept one input vector, evaluate one neuron per cycle, return a spike vector.
module lif_neuron_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int INPUTS    = 8,
  parameter int U_WIDTH   = 5,
  parameter int IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INPUTS-1:0]    in_x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_NEURONS-1:0] out_spikes,
  output logic [15:0]          step_count,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_sel,
  input  logic [IDX_W-1:0]     cfg_addr,
  input  logic [INPUTS-1:0]    cfg_data,
  output logic                 cfg_ready,
  output logic [INPUTS-1:0]    dp_w,
  output logic [INPUTS-1:0]    dp_x,
  output logic [2:0]           dp_shift,
  output logic [U_WIDTH-1:0]   dp_previus_u,
  output logic [U_WIDTH-1:0]   dp_minus_teta,
  output logic                 dp_was_spike,
  input  logic [U_WIDTH-1:0]   dp_u_out,
  input  logic                 dp_is_spike
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready is high only in IDLE; out_valid stays high (with out_spikes stable) until
  // out_ready is seen, and neither depends combinationally on the other side's signal.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]     idx;
  logic [INPUTS-1:0]    x_reg;
  logic [INPUTS-1:0]    wmem  [N_NEURONS];
  logic [U_WIDTH-1:0]   u_mem [N_NEURONS];
  logic [N_NEURONS-1:0] spk_mem;
  logic [U_WIDTH-1:0]   thr;
  logic [2:0]           shift;
  logic                 idx_last;
  logic                 addr_ok;

  assign idx_last = (idx == IDX_W'(N_NEURONS - 1));
  assign addr_ok  = ({1'b0, cfg_addr} < (IDX_W + 1)'(N_NEURONS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    cfg_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready  = 1'b1;
        cfg_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN:     if (idx_last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      x_reg      <= '0;
      spk_mem    <= '0;
      thr        <= U_WIDTH'(5);
      shift      <= 3'd0;
      out_spikes <= '0;
      out_valid  <= 1'b0;
      step_count <= 16'd0;
      for (int i = 0; i < N_NEURONS; i++) begin
        wmem[i]  <= '1;
        u_mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg <= in_x;
            idx   <= '0;
          end
          // Config and input acceptance may share an edge; the run sees the new values.
          if (cfg_we) begin
            case (cfg_sel)
              2'd0: if (addr_ok) wmem[cfg_addr] <= cfg_data;
              2'd1: thr <= cfg_data[U_WIDTH-1:0];
              2'd2: shift <= cfg_data[2:0];
              default: begin
                if (addr_ok) begin
                  u_mem[cfg_addr]   <= '0;
                  spk_mem[cfg_addr] <= 1'b0;
                end
              end
            endcase
          end
        end
        RUN: begin
          u_mem[idx]      <= dp_u_out;
          spk_mem[idx]    <= dp_is_spike;
          out_spikes[idx] <= dp_is_spike;
          if (idx_last) begin
            out_valid  <= 1'b1;
            step_count <= step_count + 16'd1;
            idx        <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign dp_w          = wmem[idx];
  assign dp_previus_u  = u_mem[idx];
  assign dp_was_spike  = spk_mem[idx];
  assign dp_x          = x_reg;
  assign dp_shift      = shift;
  assign dp_minus_teta = -thr;

endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// Directed bench for lif_neuron_scheduler using a stub datapath
// (u_out = previus_u + 1, is_spike = previus_u[0]).
module tb_lif_neuron_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_spikes;
  logic [15:0] step_count;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       cfg_ready;
  logic [7:0] dp_w;
  logic [7:0] dp_x;
  logic [2:0] dp_shift;
  logic [4:0] dp_previus_u;
  logic [4:0] dp_minus_teta;
  logic       dp_was_spike;
  logic [4:0] dp_u_out;
  logic       dp_is_spike;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign dp_u_out    = dp_previus_u + 5'd1;
  assign dp_is_spike = dp_previus_u[0];

  lif_neuron_scheduler dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_spikes(out_spikes),
    .step_count(step_count),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready),
    .dp_w(dp_w), .dp_x(dp_x), .dp_shift(dp_shift), .dp_previus_u(dp_previus_u),
    .dp_minus_teta(dp_minus_teta), .dp_was_spike(dp_was_spike),
    .dp_u_out(dp_u_out), .dp_is_spike(dp_is_spike)
  );

  task automatic cfg_write(input logic [1:0] sel, input logic [1:0] addr, input logic [7:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // One timestep from IDLE. e_prev/e_was/e_w are per-neuron expectations, neuron 0 in the LSBs.
  task automatic run_step(input string name, input logic [7:0] x, input logic [19:0] e_prev,
                          input logic [3:0] e_was, input logic [31:0] e_w, input logic [4:0] e_mt,
                          input logic [2:0] e_sh, input logic [3:0] e_spk, input logic [15:0] e_sc,
                          input int stall, input bit poke_cfg);
    in_x = x; in_valid = 1'b1; out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0; in_x = ~x;
    for (int k = 0; k < 4; k++) begin
      cfg_we = poke_cfg; cfg_sel = k[1:0]; cfg_addr = 2'd2; cfg_data = 8'h1F;
      n_total++; if (dp_x !== x) $display("FAIL %s dp_x[%0d] got %h expected %h", name, k, dp_x, x); else n_pass++;
      n_total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL %s run_flags[%0d] got in_ready=%b out_valid=%b expected 0 0", name, k, in_ready, out_valid); else n_pass++;
      n_total++; if (dp_previus_u !== e_prev[k*5 +: 5]) $display("FAIL %s prev_u[%0d] got %0d expected %0d", name, k, dp_previus_u, e_prev[k*5 +: 5]); else n_pass++;
      n_total++; if (dp_was_spike !== e_was[k]) $display("FAIL %s was_spike[%0d] got %b expected %b", name, k, dp_was_spike, e_was[k]); else n_pass++;
      n_total++; if (dp_w !== e_w[k*8 +: 8]) $display("FAIL %s dp_w[%0d] got %h expected %h", name, k, dp_w, e_w[k*8 +: 8]); else n_pass++;
      n_total++; if (dp_minus_teta !== e_mt || dp_shift !== e_sh) $display("FAIL %s cfg[%0d] got mt=%b sh=%0d expected mt=%b sh=%0d", name, k, dp_minus_teta, dp_shift, e_mt, e_sh); else n_pass++;
      @(negedge clk);
    end
    cfg_we = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      n_total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || cfg_ready !== 1'b0) $display("FAIL %s done_flags[%0d] got out_valid=%b in_ready=%b cfg_ready=%b expected 1 0 0", name, s, out_valid, in_ready, cfg_ready); else n_pass++;
      n_total++; if (out_spikes !== e_spk) $display("FAIL %s spikes[%0d] got %b expected %b", name, s, out_spikes, e_spk); else n_pass++;
      n_total++; if (step_count !== e_sc) $display("FAIL %s step_count[%0d] got %0d expected %0d", name, s, step_count, e_sc); else n_pass++;
      if (s == stall) begin
        out_ready = 1'b1; in_valid = 1'b0;
      end else begin
        in_valid = 1'b1; in_x = 8'hFF;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL %s idle_flags got in_ready=%b out_valid=%b expected 1 0", name, in_ready, out_valid); else n_pass++;
    n_total++; if (out_spikes !== e_spk || step_count !== e_sc) $display("FAIL %s idle_hold got spikes=%b sc=%0d expected %b %0d", name, out_spikes, step_count, e_spk, e_sc); else n_pass++;
    n_total++; if (dp_x !== x) $display("FAIL %s x_hold got %h expected %h", name, dp_x, x); else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_x = 8'h00; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_sel = 2'd0; cfg_addr = 2'd0; cfg_data = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1 || cfg_ready !== 1'b1) $display("FAIL reset ready got %b %b expected 1 1", in_ready, cfg_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0 || out_spikes !== 4'b0000) $display("FAIL reset out got %b %b expected 0 0000", out_valid, out_spikes); else n_pass++;
    n_total++; if (step_count !== 16'd0) $display("FAIL reset step_count got %0d expected 0", step_count); else n_pass++;
    n_total++; if (dp_w !== 8'hFF) $display("FAIL reset dp_w got %h expected ff", dp_w); else n_pass++;
    n_total++; if (dp_minus_teta !== 5'b11011) $display("FAIL reset minus_teta got %b expected 11011", dp_minus_teta); else n_pass++;
    n_total++; if (dp_shift !== 3'd0 || dp_x !== 8'h00) $display("FAIL reset shift_x got %0d %h expected 0 00", dp_shift, dp_x); else n_pass++;
  endtask

  task automatic test_sequence;
    run_step("seq1", 8'hA5, 20'd0, 4'b0000, 32'hFFFF_FFFF, 5'b11011, 3'd0, 4'b0000, 16'd1, 0, 1'b0);
    run_step("seq2", 8'h5A, {5'd1, 5'd1, 5'd1, 5'd1}, 4'b0000, 32'hFFFF_FFFF, 5'b11011, 3'd0, 4'b1111, 16'd2, 0, 1'b0);
    run_step("seq3", 8'h81, {5'd2, 5'd2, 5'd2, 5'd2}, 4'b1111, 32'hFFFF_FFFF, 5'b11011, 3'd0, 4'b0000, 16'd3, 0, 1'b0);
  endtask

  task automatic test_back_to_back_backpressure;
    run_step("bp", 8'h66, {5'd3, 5'd3, 5'd3, 5'd3}, 4'b0000, 32'hFFFF_FFFF, 5'b11011, 3'd0, 4'b1111, 16'd4, 10, 1'b0);
  endtask

  task automatic test_config;
    cfg_write(2'd3, 2'd1, 8'h00);
    cfg_write(2'd0, 2'd2, 8'h3C);
    cfg_write(2'd1, 2'd0, 8'h07);
    cfg_write(2'd2, 2'd0, 8'h03);
    n_total++; if (dp_minus_teta !== 5'b11001 || dp_shift !== 3'd3 || dp_w !== 8'hFF) $display("FAIL cfg_idle got mt=%b sh=%0d w=%h expected 11001 3 ff", dp_minus_teta, dp_shift, dp_w); else n_pass++;
    // Writes are poked every RUN cycle and must all be ignored.
    run_step("cfg", 8'h0F, {5'd4, 5'd4, 5'd0, 5'd4}, 4'b1101, {8'hFF, 8'h3C, 8'hFF, 8'hFF}, 5'b11001, 3'd3, 4'b0000, 16'd5, 0, 1'b1);
    n_total++; if (dp_minus_teta !== 5'b11001 || dp_shift !== 3'd3) $display("FAIL cfg_after_run got mt=%b sh=%0d expected 11001 3", dp_minus_teta, dp_shift); else n_pass++;
  endtask

  task automatic test_simultaneous;
    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_addr = 2'd0; cfg_data = 8'h03;
    run_step("simul", 8'hC3, {5'd5, 5'd5, 5'd1, 5'd5}, 4'b0000, {8'hFF, 8'h3C, 8'hFF, 8'hFF}, 5'b11101, 3'd3, 4'b1111, 16'd6, 0, 1'b0);
  endtask

  task automatic test_reset_mid_run;
    in_x = 8'h77; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (dp_w !== 8'h3C) $display("FAIL mid_idx2 dp_w got %h expected 3c", dp_w); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL mid_async got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_total++; if (step_count !== 16'd0 || out_spikes !== 4'b0000) $display("FAIL mid_regs got sc=%0d spk=%b expected 0 0000", step_count, out_spikes); else n_pass++;
    n_total++; if (dp_w !== 8'hFF || dp_previus_u !== 5'd0 || dp_was_spike !== 1'b0) $display("FAIL mid_mem got w=%h u=%0d ws=%b expected ff 0 0", dp_w, dp_previus_u, dp_was_spike); else n_pass++;
    n_total++; if (dp_minus_teta !== 5'b11011 || dp_shift !== 3'd0 || dp_x !== 8'h00) $display("FAIL mid_cfg got mt=%b sh=%0d x=%h expected 11011 0 00", dp_minus_teta, dp_shift, dp_x); else n_pass++;
    run_step("post_rst", 8'h12, 20'd0, 4'b0000, 32'hFFFF_FFFF, 5'b11011, 3'd0, 4'b0000, 16'd1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_back_to_back_backpressure();
    test_config();
    test_simultaneous();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
